axi_remap_slot_arbiter: RTL
===========================

// Module: axi_remap_slot_arbiter
// PURPOSE
// - Shares one ID remap table between NUM_REQ requesters, e.g. several AW/AR sources feeding a single ID remapper.
// - Round-robin arbitration picks one requester per cycle. The winner is given the lowest free slot index.
// - On release, returns the stored original ID and the owning requester.
// - Flush FSM: stops new allocations and drains the table to empty.
// PARAMETERS
// - NUM_REQ      4  number of requesters (>=2)
// - TABLE_SIZE   8  number of remap slots (>=2, power of two)
// - ID_WIDTH_IN  4  width of the original ID stored per slot
// - Derived: SLOT_W=$clog2(TABLE_SIZE), REQ_W=$clog2(NUM_REQ), CNT_W=SLOT_W+1
// PORTS
// - clk_i          in   1                  clock, rising edge
// - rst_i          in   1                  reset, synchronous, active-high
// - req_valid_i    in   NUM_REQ            per-requester allocation request
// - req_id_i       in   NUM_REQ*ID_WIDTH_IN  original ID per requester; requester i in [i*ID_WIDTH_IN +: ID_WIDTH_IN]
// - req_ready_o    out  NUM_REQ            one-hot grant; a handshake is req_valid_i[i] & req_ready_o[i]
// - alloc_valid_o  out  1                  an allocation happens this cycle
// - alloc_slot_o   out  SLOT_W             slot given to the winner (remapped ID)
// - alloc_req_o    out  REQ_W              index of the winning requester
// - rel_valid_i    in   1                  release a slot
// - rel_slot_i     in   SLOT_W             slot to release (remapped ID from the response)
// - rel_id_o       out  ID_WIDTH_IN        stored original ID of rel_slot_i (combinational)
// - rel_req_o      out  REQ_W              stored owner of rel_slot_i (combinational)
// - rel_err_o      out  1                  release aimed at an invalid slot this cycle
// - flush_i        in   1                  request a drain
// - flush_done_o   out  1                  one-cycle pulse when the drain completes
// - used_o         out  CNT_W              number of valid slots (registered)
// - stat_gnt_o     out  NUM_REQ*16         per-requester grant counters (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst_i=1, sampled on clk_i):
//   - all slots invalid; RR pointer=0; state=RUN; used_o=0; counters=0
//   - req_ready_o, alloc_valid_o, rel_err_o, flush_done_o forced to 0 while rst_i=1
//   - reset mid-transfer drops all slots with no release reported
// - Arbitration (combinational, zero latency):
//   - candidates = req_valid_i; winner = first candidate at or after the RR pointer, with wrap
//   - req_ready_o[winner]=1 only if state==RUN and at least one slot is free
//   - all other req_ready_o bits are 0; at most one grant per cycle
//   - alloc_slot_o = lowest-index invalid slot, taken from the registered table
//   - alloc_valid_o = |(req_valid_i & req_ready_o)
// - On a handshake, at the next edge:
//   - slot becomes valid, storing {req_id_i[winner], winner}
//   - RR pointer = (winner+1) mod NUM_REQ
//   - the RR pointer does not change when there is no handshake
// - Release:
//   - if rel_valid_i and slot rel_slot_i is valid: slot invalid at the next edge
//   - if the slot is already invalid: no state change, rel_err_o=1 the same cycle
//   - rel_id_o and rel_req_o always show the registered slot contents, valid or not
// - Simultaneous allocate and release:
//   - both take effect; used_o is unchanged
//   - no bypass: a slot released this cycle cannot be allocated this cycle
//   - when full, a same-cycle release does not enable a grant
// - used_o: +1 per allocation, -1 per valid release, net 0 when both; range 0..TABLE_SIZE
// - FSM:
//   - RUN -> DRAIN when flush_i=1
//   - DRAIN: no grants; releases still accepted; -> DONE when used_o==0, including on the first DRAIN cycle
//   - DONE: flush_done_o=1 for exactly one cycle -> RUN
//   - if flush_i is still 1 in RUN, DRAIN is entered again next cycle
// - Source/sink rule: req_valid_i and req_id_i must stay stable until the handshake; the arbiter does not check this
// CONFIGURATION
// - AXI_REMAP_ARB_STATS_EN defined:
//   - one 16-bit counter per requester, +1 on each of its handshakes, saturating at 16'hFFFF
//   - counters cleared by rst_i; counter i on stat_gnt_o[i*16 +: 16]
// - Not defined: stat_gnt_o tied to '0 and no counter flops are built
// TESTING
// - Reset: rst_i high 2 cycles with all req_valid_i=1 -> req_ready_o=0, used_o=0; after release, first grant goes to requester 0, slot 0.
// - Fairness: NUM_REQ=4, all requesting, no releases -> grant order 0,1,2,3,0,1,2,3; slots 0..7; req_ready_o=0 once used_o=8.
// - Full plus release: table full, rel_slot_i=3 with req_valid_i[1]=1 -> no grant that cycle; next cycle grant gets slot 3, used_o=8.
// - Lookup/error: slot 2 holds ID 4'hA from requester 2 -> release of 2 gives rel_id_o=4'hA, rel_req_o=2; a second release of 2 gives rel_err_o=1, used_o unchanged.
// - Flush: used_o=3, flush_i pulse -> no grants in DRAIN; after 3 releases flush_done_o pulses once, then grants resume.
// - Stats (AXI_REMAP_ARB_STATS_EN): 70000 grants to requester 0 with releases -> stat_gnt_o[15:0]=16'hFFFF.

Source files
------------

// File: rtl/axi_remap_slot_arbiter_if.sv
// Bundle of request, allocation, release, flush and statistics signals for the slot arbiter.
// slave: the arbiter side. master: the requester/response side that drives requests and releases.
// Signal widths are derived from the same parameters the arbiter uses.
`timescale 1ns/1ps
interface axi_remap_slot_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int TABLE_SIZE  = 8,
  parameter int ID_WIDTH_IN = 4
);
  localparam int SLOT_W = $clog2(TABLE_SIZE);
  localparam int REQ_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = SLOT_W + 1;

  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ*ID_WIDTH_IN-1:0] req_id_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic                           alloc_valid_o;
  logic [SLOT_W-1:0]              alloc_slot_o;
  logic [REQ_W-1:0]               alloc_req_o;
  logic                           rel_valid_i;
  logic [SLOT_W-1:0]              rel_slot_i;
  logic [ID_WIDTH_IN-1:0]         rel_id_o;
  logic [REQ_W-1:0]               rel_req_o;
  logic                           rel_err_o;
  logic                           flush_i;
  logic                           flush_done_o;
  logic [CNT_W-1:0]               used_o;
  logic [NUM_REQ*16-1:0]          stat_gnt_o;

  modport slave (
    input  req_valid_i, req_id_i, rel_valid_i, rel_slot_i, flush_i,
    output req_ready_o, alloc_valid_o, alloc_slot_o, alloc_req_o,
           rel_id_o, rel_req_o, rel_err_o, flush_done_o, used_o, stat_gnt_o
  );

  modport master (
    output req_valid_i, req_id_i, rel_valid_i, rel_slot_i, flush_i,
    input  req_ready_o, alloc_valid_o, alloc_slot_o, alloc_req_o,
           rel_id_o, rel_req_o, rel_err_o, flush_done_o, used_o, stat_gnt_o
  );
endinterface

// File: rtl/axi_remap_slot_arbiter.sv
// Round-robin arbiter sharing one ID remap table among NUM_REQ requesters; flush FSM drains the table.
// Latency: grant, slot choice and release lookup are combinational; table/used/pointer update at the next edge.
// Backpressure: req_ready_o drops when the table is full or a flush is active. Optional grant counters: AXI_REMAP_ARB_STATS_EN.
`timescale 1ns/1ps
module axi_remap_slot_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TABLE_SIZE  = 8,
  parameter int ID_WIDTH_IN = 4
) (
  input logic                     clk_i,
  input logic                     rst_i,
  axi_remap_slot_arbiter_if.slave bus
);
  localparam int SLOT_W = $clog2(TABLE_SIZE);
  localparam int REQ_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = SLOT_W + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t                 state, state_nxt;
  logic [TABLE_SIZE-1:0]  slot_vld;
  logic [ID_WIDTH_IN-1:0] slot_id  [TABLE_SIZE];
  logic [REQ_W-1:0]       slot_req [TABLE_SIZE];
  logic [REQ_W-1:0]       rr_ptr;
  logic [REQ_W-1:0]       winner;
  logic                   any_req;
  logic [SLOT_W-1:0]      free_slot;
  logic                   full;
  logic                   grant_ok;
  logic [NUM_REQ-1:0]     ready;
  logic                   alloc;
  logic                   rel_hit;
  logic [CNT_W-1:0]       used;
  int                     idx;

  // Round-robin pick: first requester at or after rr_ptr, wrapping; scanned from far to near so the nearest wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (bus.req_valid_i[idx]) begin
        winner  = REQ_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  // Lowest free slot from the registered table, so a same-cycle release is never reused.
  always_comb begin
    free_slot = '0;
    for (int s = TABLE_SIZE - 1; s >= 0; s--) begin
      if (!slot_vld[s]) free_slot = SLOT_W'(s);
    end
  end

  assign full     = &slot_vld;
  assign grant_ok = !rst_i && (state == ST_RUN) && !full && any_req;

  // One-hot grant to the round-robin winner when a slot is available.
  always_comb begin
    ready = '0;
    if (grant_ok) ready[winner] = 1'b1;
  end

  assign alloc   = |(bus.req_valid_i & ready);
  assign rel_hit = bus.rel_valid_i && slot_vld[bus.rel_slot_i];

  assign bus.req_ready_o   = ready;
  assign bus.alloc_valid_o = alloc;
  assign bus.alloc_slot_o  = free_slot;
  assign bus.alloc_req_o   = winner;
  assign bus.rel_id_o      = slot_id[bus.rel_slot_i];
  assign bus.rel_req_o     = slot_req[bus.rel_slot_i];
  assign bus.rel_err_o     = !rst_i && bus.rel_valid_i && !slot_vld[bus.rel_slot_i];
  assign bus.flush_done_o  = !rst_i && (state == ST_DONE);
  assign bus.used_o        = used;

  // Slot table: allocation fills the free slot, release clears the named one; they never collide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_vld <= '0;
      for (int s = 0; s < TABLE_SIZE; s++) begin
        slot_id[s]  <= '0;
        slot_req[s] <= '0;
      end
    end else begin
      if (rel_hit) slot_vld[bus.rel_slot_i] <= 1'b0;
      if (alloc) begin
        slot_vld[free_slot] <= 1'b1;
        slot_id[free_slot]  <= bus.req_id_i[int'(winner)*ID_WIDTH_IN +: ID_WIDTH_IN];
        slot_req[free_slot] <= winner;
      end
    end
  end

  // Occupancy count and round-robin pointer; the pointer moves only on a handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      used   <= '0;
      rr_ptr <= '0;
    end else begin
      used <= used + CNT_W'(alloc) - CNT_W'(rel_hit);
      if (alloc) rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

  // Flush FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Flush FSM next state: drain until empty, pulse done for one cycle, then resume.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (bus.flush_i) state_nxt = ST_DRAIN;
      ST_DRAIN: if (used == '0)  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

`ifdef AXI_REMAP_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [15:0] cnt;
    // Saturating per-requester grant counter.
    always_ff @(posedge clk_i) begin
      if (rst_i)                                             cnt <= '0;
      else if (alloc && winner == REQ_W'(g) && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign bus.stat_gnt_o[g*16 +: 16] = cnt;
  end
`else
  assign bus.stat_gnt_o = '0;
`endif

endmodule
